// File: rtl/wb_initiator_pkg.sv
// Shared definitions for Wishbone bus initiators: FSM state encodings and
// the default acknowledge timeout.
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int unsigned WB_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating acknowledge-wait counter.
// Ports:
//   clk, rstn : clock, async active-low reset
//   clr       : load zero (takes priority over en)
//   en        : count one wait cycle
//   expired   : counter has reached TIMEOUT (decoded from the count register)
module wb_timeout_ctr
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = WB_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT));

  // Holds at TIMEOUT instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator bridging a valid/ready host
// request/response interface onto the bus, with an acknowledge timeout.
// Ports:
//   clk, rstn                          : clock, async active-low reset
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_sel : host request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                 : host response
//   o_wb_cyc/stb/we/adr/dat/sel        : Wishbone initiator outputs
//   i_wb_rdt, i_wb_ack                 : Wishbone responder inputs
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = WB_DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_adr,
  output logic [DW-1:0]   o_wb_dat,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic [DW-1:0]   i_wb_rdt,
  input  logic            i_wb_ack
);

  wb_state_e       state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            ctr_clr, ctr_en, ctr_expired;

  // Handshake and bus strobes are pure state decodes: no ack-to-output path,
  // and reset drops cyc without waiting for a clock edge.
  assign req_ready = (state_q == ST_IDLE);
  assign o_wb_cyc  = (state_q == ST_BUS);
  assign o_wb_stb  = (state_q == ST_BUS);
  assign rsp_valid = (state_q == ST_RESP);
  assign o_wb_we   = we_q;
  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_sel  = sel_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (ctr_expired)
  );

  // Next-state and datapath load decisions.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          adr_d   = req_addr;
          dat_d   = req_wdata;
          sel_d   = req_sel;
          ctr_clr = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        ctr_en = !i_wb_ack;
        // Ack is checked first so it wins over a coincident timeout.
        if (i_wb_ack) begin
          rdata_d = we_q ? '0 : i_wb_rdt;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (ctr_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator. Instance dut uses TIMEOUT=4,
// instance dut3 uses TIMEOUT=3 for the ack-on-timeout-cycle case.
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata, rdt;
  logic [3:0]  req_sel;
  logic        ack_r = 1'b0;
  logic        ack_inj;
  logic        auto_ack;
  wire         ack = ack_r | ack_inj;

  logic        req_ready, rsp_valid, rsp_err, cyc, stb, we;
  logic [31:0] rsp_rdata, adr, dat;
  logic [3:0]  sel;

  logic        b_req_valid, b_rsp_ready, b_ack;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_cyc, b_stb, b_we;
  logic [31:0] b_rsp_rdata, b_adr, b_dat;
  logic [3:0]  b_sel;

  int vectors    = 0;
  int miscompares = 0;

  wb_initiator #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_adr(adr),
    .o_wb_dat(dat), .o_wb_sel(sel), .i_wb_rdt(rdt), .i_wb_ack(ack)
  );

  wb_initiator #(.AW(32), .DW(32), .TIMEOUT(3)) dut3 (
    .clk(clk), .rstn(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err),
    .o_wb_cyc(b_cyc), .o_wb_stb(b_stb), .o_wb_we(b_we), .o_wb_adr(b_adr),
    .o_wb_dat(b_dat), .o_wb_sel(b_sel), .i_wb_rdt(rdt), .i_wb_ack(b_ack)
  );

  always #5 clk = ~clk;

  // Responder with a registered ack: acks one cycle after it sees cyc.
  always @(posedge clk) ack_r <= auto_ack && cyc && !ack_r;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_sel = '0; rsp_ready = 1'b0; rdt = 32'hA5; ack_inj = 1'b0; auto_ack = 1'b0;
    b_req_valid = 1'b0; b_rsp_ready = 1'b0; b_ack = 1'b0;

    // Reset state
    step(); step();
    chk("rst_cyc", 64'(cyc), 64'd0);
    chk("rst_stb", 64'(stb), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_adr", 64'(adr), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    #2 rstn = 1'b1;
    step();
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Read with registered-ack responder, then 10 cycles of backpressure
    auto_ack = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1;
    chk("rd_ready_N", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0; req_addr = '0;
    chk("rd_cyc_N1", 64'(cyc), 64'd1);
    chk("rd_stb_N1", 64'(stb), 64'd1);
    chk("rd_adr_N1", 64'(adr), 64'h1);
    chk("rd_we_N1", 64'(we), 64'd0);
    chk("rd_ready_N1", 64'(req_ready), 64'd0);
    chk("rd_rspv_N1", 64'(rsp_valid), 64'd0);
    step();
    chk("rd_cyc_N2", 64'(cyc), 64'd1);
    chk("rd_rspv_N2", 64'(rsp_valid), 64'd0);
    step();
    chk("rd_cyc_N3", 64'(cyc), 64'd0);
    chk("rd_rspv_N3", 64'(rsp_valid), 64'd1);
    chk("rd_rdata_N3", 64'(rsp_rdata), 64'hA5);
    chk("rd_err_N3", 64'(rsp_err), 64'd0);
    // Stray acks with different data while waiting must be ignored
    ack_inj = 1'b1; rdt = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rspv", 64'(rsp_valid), 64'd1);
      chk("bp_rdata", 64'(rsp_rdata), 64'hA5);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_cyc", 64'(cyc), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    chk("bp_rspv_end", 64'(rsp_valid), 64'd1);
    step();
    rsp_ready = 1'b0;
    chk("rd_done_rspv", 64'(rsp_valid), 64'd0);
    chk("rd_done_ready", 64'(req_ready), 64'd1);
    // Ack in IDLE with no request does nothing
    step();
    chk("idle_ack_cyc", 64'(cyc), 64'd0);
    chk("idle_ack_rspv", 64'(rsp_valid), 64'd0);
    ack_inj = 1'b0; rdt = 32'hA5;
    step();

    // Write: request inputs change after acceptance; bus must hold registered values
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2; req_wdata = 32'hFF; req_sel = 4'b0001;
    step();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
    for (int i = 0; i < 2; i++) begin
      chk("wr_cyc", 64'(cyc), 64'd1);
      chk("wr_we", 64'(we), 64'd1);
      chk("wr_dat", 64'(dat), 64'hFF);
      chk("wr_sel", 64'(sel), 64'h1);
      chk("wr_adr", 64'(adr), 64'h2);
      step();
    end
    chk("wr_cyc_end", 64'(cyc), 64'd0);
    chk("wr_rspv", 64'(rsp_valid), 64'd1);
    chk("wr_rdata", 64'(rsp_rdata), 64'd0);
    chk("wr_err", 64'(rsp_err), 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_done_rspv", 64'(rsp_valid), 64'd0);

    // Timeout (TIMEOUT=4): cyc high exactly 5 cycles
    auto_ack = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("to_cyc", 64'(cyc), 64'd1);
      chk("to_rspv", 64'(rsp_valid), 64'd0);
      step();
    end
    chk("to_cyc_end", 64'(cyc), 64'd0);
    chk("to_rspv_end", 64'(rsp_valid), 64'd1);
    chk("to_err", 64'(rsp_err), 64'd1);
    chk("to_rdata", 64'(rsp_rdata), 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("to_done_ready", 64'(req_ready), 64'd1);

    // Reset mid-BUS: cyc drops with no clock edge, no response
    req_valid = 1'b1; req_addr = 32'h5;
    step();
    req_valid = 1'b0;
    chk("mr_cyc_before", 64'(cyc), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mr_cyc_async", 64'(cyc), 64'd0);
    chk("mr_stb_async", 64'(stb), 64'd0);
    chk("mr_adr_async", 64'(adr), 64'd0);
    chk("mr_err_async", 64'(rsp_err), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mr_rspv_rst", 64'(rsp_valid), 64'd0);
    end
    #2 rstn = 1'b1;
    step();
    chk("mr_ready_rel", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mr_rspv_after", 64'(rsp_valid), 64'd0);
      chk("mr_cyc_after", 64'(cyc), 64'd0);
      step();
    end

    // Ack on the timeout cycle (TIMEOUT=3, ack on 4th BUS cycle): ack wins
    rdt = 32'h5A;
    b_req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3;
    step();
    b_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("co_cyc", 64'(b_cyc), 64'd1);
      step();
    end
    chk("co_cyc_4th", 64'(b_cyc), 64'd1);
    b_ack = 1'b1;
    step();
    b_ack = 1'b0;
    chk("co_cyc_end", 64'(b_cyc), 64'd0);
    chk("co_rspv", 64'(b_rsp_valid), 64'd1);
    chk("co_err", 64'(b_rsp_err), 64'd0);
    chk("co_rdata", 64'(b_rsp_rdata), 64'h5A);
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    chk("co_done_rspv", 64'(b_rsp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, data width, a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for ack; range 1..65535.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present from host side.
REQ-007 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 req_we  input  1  1=write, 0=read.
REQ-009 req_addr  input  AW  target address.
REQ-010 req_wdata  input  DW  write data.
REQ-011 req_sel  input  DW/8  byte enables.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  host consumes response.
REQ-014 rsp_rdata  output  DW  read data (0 for writes and errors).
REQ-015 rsp_err  output  1  1 = bus timeout.
REQ-016 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  Wishbone cycle, strobe and write enable.
REQ-017 o_wb_adr  output  AW;  o_wb_dat  output  DW;  o_wb_sel  output  DW/8.
REQ-018 i_wb_rdt  input  DW  read data from the responder; i_wb_ack  input  1  responder acknowledge.

Function
REQ-019 SHALL implement the FSM IDLE -> BUS -> RESP -> IDLE, with one outstanding transaction at a time.
REQ-020 IDLE: req_ready=1; on req_valid&req_ready, register we, addr, wdata and sel, clear the timeout counter, and go to BUS.
REQ-021 BUS: o_wb_cyc=o_wb_stb=1; o_wb_we, o_wb_adr, o_wb_dat and o_wb_sel are driven from the registered values and held stable; req_ready=0.
REQ-022 BUS: when i_wb_ack is sampled high, capture i_wb_rdt (reads only, else 0), set rsp_err=0, and go to RESP; cyc and stb are low in the next cycle.
REQ-023 BUS: the counter increments each cycle without ack; when the counter equals TIMEOUT with no ack, set rsp_err=1 and rsp_rdata=0, then go to RESP.
REQ-024 If ack and timeout coincide in the same cycle, ack SHALL win (rsp_err=0).
REQ-025 RESP: rsp_valid=1 with rsp_rdata and rsp_err held stable until rsp_ready=1; then go to IDLE in the following cycle.
REQ-026 cyc and stb SHALL be 0 in IDLE and RESP; the design is not pipelined (no back-to-back stb).
REQ-027 Any i_wb_ack outside BUS SHALL be ignored.
REQ-028 Minimum latency: request accepted in cycle N, cyc high in N+1, ack in N+2 (responder with registered ack), rsp_valid in N+3.
REQ-029 The counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrap.
REQ-030 All outputs SHALL be registered or decoded from state only; no combinational path from i_wb_ack to o_wb_* outputs.

Reset
REQ-031 rstn low SHALL force, asynchronously: state=IDLE, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_adr=o_wb_dat=o_wb_sel=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
REQ-032 Reset during BUS or RESP SHALL abandon the transaction with no response issued; cyc drops immediately.
REQ-033 After rstn deasserts, req_ready=1 in the first clock.

Structure
REQ-034 State encodings (IDLE=2'd0, BUS=2'd1, RESP=2'd2) and the default TIMEOUT SHALL live in a shared defines header used by all bus initiators.
REQ-035 The timeout counter SHALL be a sub-module wb_timeout_ctr (inputs clr and en; output expired); everything else is flat.

Verification
REQ-036 Read: req addr=0x01, we=0, with a responder that acks one cycle after cyc and returns 0xA5 -> cyc high exactly 2 cycles; rsp_valid with rsp_rdata=0xA5, rsp_err=0, 3 cycles after acceptance.
REQ-037 Write: addr=0x02, wdata=0xFF, sel=4'b0001 -> o_wb_we=1, o_wb_dat=0xFF, o_wb_sel=0x1 stable throughout cyc; rsp_rdata=0, rsp_err=0.
REQ-038 Timeout: TIMEOUT=4, no ack -> cyc high 5 cycles then low; rsp_err=1, rsp_rdata=0.
REQ-039 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, cyc=0 throughout.
REQ-040 Reset mid-BUS: assert rstn low while cyc=1 -> cyc=0 with no clock edge, rsp_valid never asserts, req_ready=1 after release.
REQ-041 Ack on the timeout cycle (TIMEOUT=3, ack on the 4th BUS cycle) -> rsp_err=0 and data captured.
